// File: rtl/bfxp_pkg.sv
// Shared types for the bit-field place sequencer: descriptor layout and FSM states.
package bfxp_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SEL_W   = 5;
    localparam int unsigned FIELD_W = 15;

    // Descriptor packs as {start, len, dest}, start in the top bits.
    typedef struct packed {
        logic [SEL_W-1:0] start;
        logic [SEL_W-1:0] len;
        logic [SEL_W-1:0] dest;
    } desc_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bfxp_field_unit.sv
// Combinational rotate-and-mask unit: places one bit field of din into acc.
module bfxp_field_unit
    import bfxp_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] acc,
    input  logic [SEL_W-1:0]  start,
    input  logic [SEL_W-1:0]  len,
    input  logic [SEL_W-1:0]  dest,
    output logic [DATA_W-1:0] acc_next,
    output logic              illegal
);

    logic [SEL_W-1:0]  w_sh;
    logic [SEL_W:0]    w_end;
    logic [DATA_W-1:0] w_rot;
    logic [DATA_W-1:0] w_mask;

    // Rotate right so bit 'start' lands on bit 'dest'; the 5-bit subtract wraps mod 32.
    always_comb begin
        w_sh     = start - dest;
        w_rot    = (din >> w_sh) | (din << ((SEL_W+1)'(DATA_W) - {1'b0, w_sh}));
        w_end    = {1'b0, dest} + {1'b0, len};
        w_mask   = ((DATA_W'(1) << len) - DATA_W'(1)) << dest;
        illegal  = (len != '0) && (w_end > (SEL_W+1)'(DATA_W));
        acc_next = acc;
        if ((len != '0) && !illegal) begin
            acc_next = acc | (w_rot & w_mask);
        end
    end

endmodule

// File: rtl/bfxp_sequencer.sv
// Multi-field bit-field place sequencer: applies up to NFIELDS descriptors, one per cycle,
// then returns the accumulated word over a valid/ready response channel.
module bfxp_sequencer
    import bfxp_pkg::*;
#(
    parameter int unsigned NFIELDS = 4,
    parameter int unsigned CW      = $clog2(NFIELDS + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [DATA_W-1:0]          req_rs1,
    input  logic [DATA_W-1:0]          req_rs2,
    input  logic [CW-1:0]              req_count,
    input  logic [FIELD_W*NFIELDS-1:0] req_fields,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_W-1:0]          resp_rd,
    output logic                       resp_err,
    output logic                       busy
);

    localparam int unsigned IW = (NFIELDS > 1) ? $clog2(NFIELDS) : 1;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_last;
    logic              w_cnt_over;
    logic [CW-1:0]     w_cnt_eff;

    logic [DATA_W-1:0] r_rs1;
    logic [DATA_W-1:0] r_acc;
    logic              r_err;
    logic [CW-1:0]     r_count;
    logic [IW-1:0]     r_idx;
    desc_t             r_fields [NFIELDS];

    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rd;
    logic              r_resp_err;
    logic              r_busy;

    desc_t             w_desc;
    logic [DATA_W-1:0] w_acc_next;
    logic              w_illegal;

    assign w_cnt_over = req_count > CW'(NFIELDS);
    assign w_cnt_eff  = w_cnt_over ? CW'(NFIELDS) : req_count;
    assign w_desc     = r_fields[r_idx];
    assign w_last     = (CW'(r_idx) + CW'(1)) == r_count;

    bfxp_field_unit u_field (
        .din      (r_rs1),
        .acc      (r_acc),
        .start    (w_desc.start),
        .len      (w_desc.len),
        .dest     (w_desc.dest),
        .acc_next (w_acc_next),
        .illegal  (w_illegal)
    );

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = (w_cnt_eff == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, operand latches, accumulator and registered response.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_rd    <= '0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_rs1        <= '0;
            r_acc        <= '0;
            r_err        <= 1'b0;
            r_count      <= '0;
            r_idx        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_busy       <= (w_state_next != ST_IDLE);
            r_resp_valid <= (w_state_next == ST_DONE);
            if (w_accept) begin
                r_rs1   <= req_rs1;
                r_acc   <= req_rs2;
                r_err   <= w_cnt_over;
                r_count <= w_cnt_eff;
                r_idx   <= '0;
                for (int i = 0; i < int'(NFIELDS); i++) begin
                    r_fields[i] <= desc_t'(req_fields[FIELD_W*i +: FIELD_W]);
                end
                // A zero-length request responds immediately with the untouched accumulator.
                if (w_cnt_eff == '0) begin
                    r_resp_rd  <= req_rs2;
                    r_resp_err <= w_cnt_over;
                end
            end
            if (r_state == ST_RUN) begin
                r_acc <= w_acc_next;
                r_err <= r_err | w_illegal;
                r_idx <= r_idx + IW'(1);
                if (w_last) begin
                    r_resp_rd  <= w_acc_next;
                    r_resp_err <= r_err | w_illegal;
                end
            end
        end
    end

    // Ready is forced low while reset is asserted, even before the first reset edge.
    assign req_ready  = (r_state == ST_IDLE) && !reset;
    assign resp_valid = r_resp_valid;
    assign resp_rd    = r_resp_rd;
    assign resp_err   = r_resp_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_bfxp_sequencer.sv
// Self-checking bench for bfxp_sequencer: scenario tasks with a result scoreboard.
module tb_bfxp_sequencer;

    localparam int N  = 4;
    localparam int CW = 3;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [31:0]     req_rs1 = '0;
    logic [31:0]     req_rs2 = '0;
    logic [CW-1:0]   req_count = '0;
    logic [15*N-1:0] req_fields = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [31:0]     resp_rd;
    logic            resp_err;
    logic            busy;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    bfxp_sequencer #(.NFIELDS(N), .CW(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_count  (req_count),
        .req_fields (req_fields),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    function automatic logic [14:0] fld(input int s, input int l, input int d);
        logic [14:0] v;
        v = {5'(s), 5'(l), 5'(d)};
        return v;
    endfunction

    // Bit-by-bit reference: bit dest+k of the result takes rs1[(start+k) mod 32].
    function automatic logic [32:0] model(input logic [31:0] rs1, input logic [31:0] rs2,
                                          input int cnt, input logic [15*N-1:0] f);
        logic [31:0] acc;
        logic        err;
        int          n;
        logic [14:0] d;
        int          s, l, t;
        acc = rs2;
        err = (cnt > N);
        n   = (cnt > N) ? N : cnt;
        for (int i = 0; i < n; i++) begin
            d = f[15*i +: 15];
            s = int'(d[14:10]);
            l = int'(d[9:5]);
            t = int'(d[4:0]);
            if (l != 0) begin
                if (t + l > 32) err = 1'b1;
                else for (int k = 0; k < l; k++) acc[t+k] = acc[t+k] | rs1[(s+k)%32];
            end
        end
        return {err, acc};
    endfunction

    task automatic send(input logic [31:0] rs1, input logic [31:0] rs2, input int cnt,
                        input logic [15*N-1:0] f, input logic [31:0] erd, input logic eerr);
        exp_t e;
        int   n;
        e.rd  = erd;
        e.err = eerr;
        e.lat = ((cnt > N) ? N : cnt) + 1;
        sb.push_back(e);
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clock); #1; n++;
        end
        n_checks++;
        if (n >= 50) begin
            n_fail++;
            $display("FAIL send_ready_timeout: req_ready=%b required 1", req_ready);
        end
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_count  = CW'(cnt);
        req_fields = f;
        req_valid  = 1'b1;
        @(posedge clock); #1;
        req_valid  = 1'b0;
    endtask

    task automatic collect(input string name, input bit chk_lat);
        exp_t e;
        int   n;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard_empty: size=0 required >0", name);
            return;
        end
        e = sb.pop_front();
        n = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            @(posedge clock); #1; n++;
        end
        n_checks++;
        if (resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid_timeout: resp_valid=%b required 1", name, resp_valid);
            return;
        end
        if (chk_lat) begin
            n_checks++;
            if (n + 1 !== e.lat) begin
                n_fail++;
                $display("FAIL %s_latency: got accept+%0d required accept+%0d", name, n + 1, e.lat);
            end
        end
        n_checks++;
        if (resp_rd !== e.rd) begin
            n_fail++;
            $display("FAIL %s_rd: got %h required %h", name, resp_rd, e.rd);
        end
        n_checks++;
        if (resp_err !== e.err) begin
            n_fail++;
            $display("FAIL %s_err: got %b required %b", name, resp_err, e.err);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: valid=%b ready=%b busy=%b required 0 1 0",
                     name, resp_valid, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0 ||
            resp_rd !== 32'h0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b valid=%b busy=%b rd=%h err=%b required 0 0 0 0 0",
                     req_ready, resp_valid, busy, resp_rd, resp_err);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_single();
        send(32'h0000_00AB, 32'h0, 1, {45'h0, fld(0, 8, 8)}, 32'h0000_AB00, 1'b0);
        collect("single", 1'b1);
    endtask

    task automatic test_count_zero();
        send(32'h1234_5678, 32'hDEAD_BEEF, 0, {4{fld(0, 8, 8)}}, 32'hDEAD_BEEF, 1'b0);
        collect("count_zero", 1'b1);
    endtask

    task automatic test_wrap();
        send(32'h8000_0001, 32'h0, 1, {45'h0, fld(31, 2, 0)}, 32'h0000_0003, 1'b0);
        collect("wrap", 1'b1);
    endtask

    task automatic test_multi();
        send(32'h1234_5678, 32'h0, 3,
             {15'h0, fld(28, 4, 0), fld(4, 4, 24), fld(0, 4, 28)}, 32'h8700_0001, 1'b0);
        collect("multi", 1'b1);
    endtask

    task automatic test_errors();
        send(32'hFFFF_FFFF, 32'h5, 1, {45'h0, fld(0, 4, 30)}, 32'h0000_0005, 1'b1);
        collect("err_overflow", 1'b1);
        send(32'hFFFF_FFFF, 32'h0, 7,
             {fld(0, 4, 12), fld(0, 4, 8), fld(0, 4, 4), fld(0, 4, 0)}, 32'h0000_FFFF, 1'b1);
        collect("err_count", 1'b1);
        send(32'hFFFF_FFFF, 32'h0, 1, {45'h0, fld(3, 0, 31)}, 32'h0000_0000, 1'b0);
        collect("len_zero", 1'b1);
    endtask

    task automatic test_backpressure();
        int n;
        send(32'hA5A5_A5A5, 32'h0, 2, {30'h0, fld(0, 8, 31), fld(0, 8, 0)}, 32'h0000_00A5, 1'b1);
        n = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            @(posedge clock); #1; n++;
        end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (resp_valid !== 1'b1 || resp_rd !== 32'h0000_00A5 || resp_err !== 1'b1 ||
                req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: valid=%b rd=%h err=%b ready=%b required 1 000000a5 1 0",
                         c, resp_valid, resp_rd, resp_err, req_ready);
            end
            @(posedge clock); #1;
        end
        collect("backpressure", 1'b0);
    endtask

    task automatic test_reset_mid_run();
        send(32'hFFFF_FFFF, 32'h0, 4, {4{fld(0, 4, 0)}}, 32'h0, 1'b0);
        void'(sb.pop_back());
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: busy=%b valid=%b ready=%b required 0 0 0",
                     busy, resp_valid, req_ready);
        end
        reset = 1'b0;
        #1;
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_mid_run_idle[%0d]: valid=%b ready=%b required 0 1",
                         c, resp_valid, req_ready);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [32:0] m;
        logic [15*N-1:0] fa, fb;
        fa = {fld(8, 8, 24), fld(0, 8, 16), 30'h0};
        fb = {30'h0, fld(16, 16, 0), fld(0, 16, 16)};
        m = model(32'hCAFE_F00D, 32'h1, 4, fa);
        e.rd = m[31:0]; e.err = m[32]; e.lat = 5;
        sb.push_back(e);
        req_rs1 = 32'hCAFE_F00D; req_rs2 = 32'h1; req_count = CW'(4); req_fields = fa;
        req_valid = 1'b1;
        @(posedge clock); #1;
        // Held request switches to B while A runs; A must be unaffected.
        req_rs1 = 32'h1357_9BDF; req_rs2 = 32'h0; req_count = CW'(2); req_fields = fb;
        collect("b2b_first", 1'b1);
        m = model(32'h1357_9BDF, 32'h0, 2, fb);
        e.rd = m[31:0]; e.err = m[32]; e.lat = 3;
        sb.push_back(e);
        @(posedge clock); #1;
        req_valid = 1'b0;
        collect("b2b_second", 1'b1);
    endtask

    task automatic test_random();
        logic [31:0]     rs1, rs2;
        logic [15*N-1:0] f;
        logic [32:0]     m;
        int              cnt;
        for (int t = 0; t < 12; t++) begin
            rs1 = $urandom; rs2 = $urandom;
            for (int i = 0; i < N; i++) f[15*i +: 15] = 15'($urandom);
            cnt = $urandom_range(0, 7);
            m   = model(rs1, rs2, cnt, f);
            send(rs1, rs2, cnt, f, m[31:0], m[32]);
            collect("random", 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_count_zero();
        test_wrap();
        test_multi();
        test_errors();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
